// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO read-side logic:
// default word width and skid-buffer occupancy encoding.
package fifo_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    OCC_0 = 2'd0,
    OCC_1 = 2'd1,
    OCC_2 = 2'd2
  } occ_e;

  function automatic logic [2:0] occ_count(input occ_e occ);
    return {1'b0, logic'(occ[1]), logic'(occ[0])};
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for fifo_rd_stream.
// master = drain engine side, slave = FIFO/downstream environment side.
interface fifo_rd_stream_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = fifo_pkg::DATA_W
) ();

  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_rd_data, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_rd_data, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );

endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry skid buffer: head presents the current word, tail catches the
// word still arriving from the FIFO while downstream is stalled.
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = fifo_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output occ_e              o_occ,
  output logic [DATA_W-1:0] o_head
);

  occ_e              r_occ;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_occ  <= OCC_0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case (r_occ)
        OCC_0: begin
          if (i_push) begin
            r_head <= i_data;
            r_occ  <= OCC_1;
          end
        end
        OCC_1: begin
          if (i_push && i_pop) begin
            r_head <= i_data;
          end else if (i_push) begin
            r_tail <= i_data;
            r_occ  <= OCC_2;
          end else if (i_pop) begin
            r_occ  <= OCC_0;
          end
        end
        // Credit logic upstream guarantees no push while full.
        OCC_2: begin
          if (i_pop) begin
            r_head <= r_tail;
            r_occ  <= OCC_1;
          end
        end
        default: r_occ <= OCC_0;
      endcase
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_head;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain drain engine: pops the FIFO and re-presents words as a
// valid/ready stream at full rate. Define RD_WCOUNT_EN for rd_word_cnt.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = fifo_pkg::DATA_W
) (
  input  logic              rd_clk,
  input  logic              rd_rst_n,
  fifo_rd_stream_if.master  bus
`ifdef RD_WCOUNT_EN
  ,
  output logic [15:0]       rd_word_cnt
`endif
);

  occ_e              w_occ;
  logic [DATA_W-1:0] w_head;
  logic              w_valid;
  logic              w_pop;
  logic              w_rd_en;
  logic [2:0]        w_credit_used;
  logic              r_inflight;

  assign w_valid = (w_occ != OCC_0);
  assign w_pop   = w_valid & bus.m_ready;

  // Slots committed after this edge: buffered + arriving - leaving.
  // pop implies occ >= 1, so this never underflows.
  assign w_credit_used = occ_count(w_occ) + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_en       = rd_rst_n & ~bus.fifo_empty & (w_credit_used < 3'd2);

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
    end
  end

  rd_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .i_clk   (rd_clk),
    .i_rst_n (rd_rst_n),
    .i_push  (r_inflight),
    .i_data  (bus.fifo_rd_data),
    .i_pop   (w_pop),
    .o_occ   (w_occ),
    .o_head  (w_head)
  );

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_valid    = w_valid;
  assign bus.m_data     = w_head;

`ifdef RD_WCOUNT_EN
  logic [15:0] r_word_cnt;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_word_cnt <= '0;
    end else if (w_pop) begin
      r_word_cnt <= r_word_cnt + 16'd1;
    end
  end

  assign rd_word_cnt = r_word_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: a directed vector table, directed
// streaming/backpressure sequences and a randomized run against a queue-based FIFO model.
`timescale 1ns/1ps
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int unsigned W = 16;

  logic rd_clk   = 1'b0;
  logic rd_rst_n = 1'b0;
  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream_if #(.DATA_W(W)) bus ();
`ifdef RD_WCOUNT_EN
  logic [15:0] rd_word_cnt;
`endif

  fifo_rd_stream #(.DATA_W(W)) dut (
    .rd_clk   (rd_clk),
    .rd_rst_n (rd_rst_n),
    .bus      (bus)
`ifdef RD_WCOUNT_EN
    ,
    .rd_word_cnt (rd_word_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural FIFO + stream model ----------------
  logic [W-1:0] src_q[$];   // words still sitting in the FIFO
  logic [W-1:0] exp_q[$];   // words popped from the FIFO, not yet delivered
  bit           force_empty;
  bit           rdy;
  bit           pend_v;
  logic [W-1:0] pend_d;
  bit           prev_stall;
  logic [W-1:0] prev_data;
  int           pops;
  bit           last_en;
  bit           last_v;

  // One read-clock cycle: drive at negedge, sample 1ns later, wait next negedge.
  task automatic tick();
    bit           emp;
    logic         en;
    logic         v;
    logic [W-1:0] d;
    emp              = force_empty || (src_q.size() == 0);
    bus.fifo_empty   = emp;
    bus.m_ready      = rdy;
    bus.fifo_rd_data = pend_v ? pend_d : W'(16'hDEAD);
    #1;
    en = bus.fifo_rd_en;
    v  = bus.m_valid;
    d  = bus.m_data;
    check("rd_en_while_empty", {31'b0, en & emp}, 32'd0);
    if (prev_stall) begin
      check("stall_valid_hold", {31'b0, v}, 32'd1);
      check("stall_data_hold", {16'b0, d}, {16'b0, prev_data});
    end
    if (v && rdy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_word: got %0h expected no word", d);
      end else begin
        check("data_order", {16'b0, d}, {16'b0, exp_q.pop_front()});
      end
      pops++;
    end
    if (en && !emp) begin
      pend_d = src_q.pop_front();
      exp_q.push_back(pend_d);
    end
    pend_v = en;
    check("outstanding_le2", {31'b0, exp_q.size() <= 2}, 32'd1);
    prev_stall = v && !rdy;
    prev_data  = d;
    last_en    = en;
    last_v     = v;
    @(negedge rd_clk);
  endtask

  task automatic do_reset();
    rd_rst_n         = 1'b0;
    src_q.delete();
    exp_q.delete();
    pend_v           = 1'b0;
    prev_stall       = 1'b0;
    force_empty      = 1'b0;
    rdy              = 1'b0;
    pops             = 0;
    bus.fifo_empty   = 1'b1;
    bus.m_ready      = 1'b0;
    bus.fifo_rd_data = '0;
    repeat (2) @(negedge rd_clk);
    rd_rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         rst_n;
    logic         empty;
    logic         ready;
    logic [W-1:0] rdata;
    logic         exp_en;
    logic         exp_valid;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int first_v;
    int last_vc;
    int nv;
    int en_cnt;
    int gen;
    int c;

    // reset hold, single-word latency, async reset mid-run
    vecs[0] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 16'hA5A5, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 16'hA5A5};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 16'hA5A5};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000};

    bus.fifo_empty   = 1'b0;
    bus.m_ready      = 1'b1;
    bus.fifo_rd_data = '0;
    @(negedge rd_clk);
    for (int i = 0; i < 8; i++) begin
      rd_rst_n         = vecs[i].rst_n;
      bus.fifo_empty   = vecs[i].empty;
      bus.m_ready      = vecs[i].ready;
      bus.fifo_rd_data = vecs[i].rdata;
      #1;
      check($sformatf("vec%0d_rd_en", i), {31'b0, bus.fifo_rd_en}, {31'b0, vecs[i].exp_en});
      check($sformatf("vec%0d_valid", i), {31'b0, bus.m_valid}, {31'b0, vecs[i].exp_valid});
      check($sformatf("vec%0d_data", i), {16'b0, bus.m_data}, {16'b0, vecs[i].exp_data});
      @(negedge rd_clk);
    end

    // streaming: 8 words back to back
    do_reset();
    for (int i = 1; i <= 8; i++) src_q.push_back(W'(i));
    rdy     = 1'b1;
    first_v = -1;
    last_vc = -1;
    nv      = 0;
    c       = 0;
    while (c < 40 && pops < 8) begin
      tick();
      if (last_v) begin
        if (first_v < 0) first_v = c;
        last_vc = c;
        nv++;
      end
      c++;
    end
    check("stream_words", pops, 32'd8);
    check("stream_first_valid_cycle", first_v, 32'd2);
    check("stream_span", last_vc - first_v, 32'd7);
    check("stream_valid_cycles", nv, 32'd8);
`ifdef RD_WCOUNT_EN
    check("stream_word_cnt", {16'b0, rd_word_cnt}, 32'd8);
`endif

    // backpressure: 4 words, ready low 5 cycles
    do_reset();
    for (int i = 0; i < 4; i++) src_q.push_back(W'(16'hB000 + i));
    rdy    = 1'b0;
    en_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (last_en) en_cnt++;
    end
    check("stall_rd_en_le2", {31'b0, en_cnt <= 2}, 32'd1);
    rdy = 1'b1;
    c   = 0;
    while (c < 30 && pops < 4) begin
      tick();
      c++;
    end
    check("bp_words", pops, 32'd4);

    // random ready / empty, 1000 words
    do_reset();
    gen = 0;
    c   = 0;
    while (c < 20000 && pops < 1000) begin
      rdy         = ($urandom_range(0, 1) == 1);
      force_empty = ($urandom_range(0, 3) == 0);
      if (gen < 1000 && src_q.size() < 6 && $urandom_range(0, 1) == 1) begin
        src_q.push_back(W'($urandom));
        gen++;
      end
      tick();
      c++;
    end
    check("random_words", pops, 32'd1000);
    check("random_leftover", exp_q.size(), 32'd0);

`ifdef RD_WCOUNT_EN
    // counter wrap after 65537 accepted words
    do_reset();
    rdy = 1'b1;
    gen = 0;
    c   = 0;
    while (c < 66000 && pops < 65537) begin
      if (gen < 65537 && src_q.size() < 4) begin
        src_q.push_back(W'(gen));
        gen++;
      end
      tick();
      c++;
    end
    check("wrap_words", pops, 32'd65537);
    check("wrap_word_cnt", {16'b0, rd_word_cnt}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
